// File: rtl/sha_stream_out.sv
// Serializes a captured 1600-bit Keccak state as an AXI-Stream digest of
// DATA_WIDTH-bit words, truncated to the selected digest length.
module sha_stream_out #(
  parameter int DATA_WIDTH = 64,
  parameter bit BYTE_SWAP  = 1'b0
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [4:0][4:0][63:0]        Din,
  input  logic [1:0]                   TID,
  input  logic                         Mode,
  input  logic                         start,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic [DATA_WIDTH/8-1:0]      m_tkeep,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast,
  output logic [1:0]                   m_tid,
  output logic                         busy,
  output logic                         start_drop
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int NW = 1600 / DATA_WIDTH;
  localparam int IW = $clog2(NW);
  localparam logic [11:0] DWL = 12'(DATA_WIDTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                       state_q;
  logic [1599:0]                s_q;
  logic [7:0]                   cnt_q;
  logic [7:0]                   lim_q;
  logic [10:0]                  bits_q;

  logic [1599:0]                dinFlat;
  logic [1599:0]                sIn;
  logic [1599:0]                src;
  logic [63:0]                  lane;
  logic [NW-1:0][DATA_WIDTH-1:0] srcWords;
  logic [7:0]                   cnt_d;
  logic [7:0]                   lim_d;
  logic [10:0]                  bits_d;
  logic [11:0]                  wordBase;
  logic [DATA_WIDTH-1:0]        data_d;
  logic [NB-1:0]                keep_d;
  logic                         last_d;
  logic                         handshake;
  logic                         isLast;
  logic                         capture;
  logic                         drop;

  function automatic logic [10:0] digestBits(input logic [1:0] tid, input logic mode);
    if (mode) return 11'd1600;
    case (tid)
      2'd0:    return 11'd224;
      2'd1:    return 11'd256;
      2'd2:    return 11'd384;
      default: return 11'd512;
    endcase
  endfunction

  // Lane k of the stream is Din[4-k/5][4-k%5], i.e. packed lane 24-k.
  assign dinFlat = Din;
  always_comb begin
    sIn  = '0;
    lane = '0;
    for (int k = 0; k < 25; k++) begin
      lane = dinFlat[64*(24-k) +: 64];
      for (int b = 0; b < 8; b++) begin
        if (BYTE_SWAP) sIn[64*k + 8*b +: 8] = lane[8*(7-b) +: 8];
        else           sIn[64*k + 8*b +: 8] = lane[8*b +: 8];
      end
    end
  end

  assign handshake = m_tvalid & m_tready;
  assign isLast    = (cnt_q == lim_q - 8'd1);
  assign capture   = start & ((state_q == IDLE) | (handshake & isLast));
  assign drop      = start & (state_q == SEND) & ~(handshake & isLast);

  // Next presented word comes from the fresh capture or the held state.
  always_comb begin
    src      = capture ? sIn : s_q;
    srcWords = src;
    cnt_d    = capture ? 8'd0 : cnt_q + 8'd1;
    bits_d   = capture ? digestBits(TID, Mode) : bits_q;
    lim_d    = capture ? 8'((12'(bits_d) + DWL - 12'd1) / DWL) : lim_q;
    wordBase = 12'(cnt_d) * DWL;
    data_d   = srcWords[cnt_d[IW-1:0]];
    keep_d   = '0;
    for (int j = 0; j < NB; j++) begin
      keep_d[j] = (wordBase + 12'(8 * (j + 1))) <= 12'(bits_d);
      if (!keep_d[j]) data_d[8*j +: 8] = 8'h00;
    end
    last_d = (cnt_d == lim_d - 8'd1);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      s_q        <= '0;
      cnt_q      <= '0;
      lim_q      <= '0;
      bits_q     <= '0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tid      <= '0;
      busy       <= 1'b0;
      start_drop <= 1'b0;
    end else begin
      start_drop <= drop;
      if (capture) begin
        state_q  <= SEND;
        s_q      <= sIn;
        cnt_q    <= 8'd0;
        lim_q    <= lim_d;
        bits_q   <= bits_d;
        m_tid    <= TID;
        m_tvalid <= 1'b1;
        busy     <= 1'b1;
        m_tdata  <= data_d;
        m_tkeep  <= keep_d;
        m_tlast  <= last_d;
      end else if (handshake) begin
        if (isLast) begin
          state_q  <= IDLE;
          m_tvalid <= 1'b0;
          busy     <= 1'b0;
          m_tlast  <= 1'b0;
          m_tdata  <= '0;
          m_tkeep  <= '0;
        end else begin
          cnt_q   <= cnt_d;
          m_tdata <= data_d;
          m_tkeep <= keep_d;
          m_tlast <= last_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha_stream_out.sv
// Randomized bench for sha_stream_out: three configurations checked against a
// byte-level digest model driven one clock step at a time.
module tb_sha_stream_out;

  typedef logic [4:0][4:0][63:0] keccak_t;

  logic    ACLK = 1'b0;
  logic    ARESETn;
  keccak_t dinDrv;
  logic [1:0] tidDrv;
  logic    modeDrv, startDrv, readyDrv;
  int      sel;
  bit      forceLane0;

  logic [63:0] dataA, dataC;
  logic [15:0] dataB;
  logic [7:0]  keepA, keepC;
  logic [1:0]  keepB, tidA, tidB, tidC;
  logic validA, validB, validC, lastA, lastB, lastC;
  logic busyA, busyB, busyC, dropA, dropB, dropC;

  logic [63:0] obsData;
  logic [7:0]  obsKeep;
  logic [1:0]  obsTid;
  logic obsValid, obsLast, obsBusy, obsDrop;

  int vectorCount = 0;
  int missCount = 0;

  int curDW;
  bit curSwap;
  bit mValid;
  int mIdx, mL, mBits, hsCount;
  bit mDrop;
  logic [1:0] mTid;
  logic [1599:0] mS;
  int bitsTable [4] = '{224, 256, 384, 512};

  always #5 ACLK = ~ACLK;

  sha_stream_out #(.DATA_WIDTH(64), .BYTE_SWAP(1'b0)) dutA (
    .ACLK(ACLK), .ARESETn(ARESETn), .Din(dinDrv), .TID(tidDrv), .Mode(modeDrv),
    .start(startDrv && sel == 0), .m_tdata(dataA), .m_tkeep(keepA), .m_tvalid(validA),
    .m_tready(readyDrv && sel == 0), .m_tlast(lastA), .m_tid(tidA), .busy(busyA),
    .start_drop(dropA));

  sha_stream_out #(.DATA_WIDTH(16), .BYTE_SWAP(1'b0)) dutB (
    .ACLK(ACLK), .ARESETn(ARESETn), .Din(dinDrv), .TID(tidDrv), .Mode(modeDrv),
    .start(startDrv && sel == 1), .m_tdata(dataB), .m_tkeep(keepB), .m_tvalid(validB),
    .m_tready(readyDrv && sel == 1), .m_tlast(lastB), .m_tid(tidB), .busy(busyB),
    .start_drop(dropB));

  sha_stream_out #(.DATA_WIDTH(64), .BYTE_SWAP(1'b1)) dutC (
    .ACLK(ACLK), .ARESETn(ARESETn), .Din(dinDrv), .TID(tidDrv), .Mode(modeDrv),
    .start(startDrv && sel == 2), .m_tdata(dataC), .m_tkeep(keepC), .m_tvalid(validC),
    .m_tready(readyDrv && sel == 2), .m_tlast(lastC), .m_tid(tidC), .busy(busyC),
    .start_drop(dropC));

  always_comb begin
    obsData = '0; obsKeep = '0; obsTid = '0;
    obsValid = 1'b0; obsLast = 1'b0; obsBusy = 1'b0; obsDrop = 1'b0;
    case (sel)
      0: begin obsData = dataA; obsKeep = keepA; obsTid = tidA; obsValid = validA;
               obsLast = lastA; obsBusy = busyA; obsDrop = dropA; end
      1: begin obsData = {48'h0, dataB}; obsKeep = {6'h0, keepB}; obsTid = tidB; obsValid = validB;
               obsLast = lastB; obsBusy = busyB; obsDrop = dropB; end
      default: begin obsData = dataC; obsKeep = keepC; obsTid = tidC; obsValid = validC;
               obsLast = lastC; obsBusy = busyC; obsDrop = dropC; end
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  function automatic logic [1599:0] specState(input keccak_t din, input bit swap);
    logic [1599:0] s;
    logic [63:0] lane;
    s = '0;
    for (int k = 0; k < 25; k++) begin
      lane = din[4 - k/5][4 - k%5];
      if (swap) lane = {<<8{lane}};
      s[64*k +: 64] = lane;
    end
    return s;
  endfunction

  // Digest as a byte stream: byte n of S while n*8 < bits, otherwise dropped.
  function automatic void modelWord(input logic [1599:0] s, input int bits, input int idx,
                                    input int dw, output logic [63:0] d, output logic [7:0] k);
    int nb, byteN;
    nb = dw / 8;
    d = '0;
    k = '0;
    for (int j = 0; j < nb; j++) begin
      byteN = idx * nb + j;
      if (byteN * 8 < bits) begin
        d[8*j +: 8] = s[8*byteN +: 8];
        k[j] = 1'b1;
      end
    end
  endfunction

  function automatic keccak_t randomDin();
    keccak_t r;
    for (int a = 0; a < 5; a++)
      for (int b = 0; b < 5; b++)
        r[a][b] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic applyStimulus(input bit rdy, input bit st);
    bit hs, lastHs, cap, wasStall;
    logic [63:0] prevData, d;
    logic [7:0] prevKeep, k;
    dinDrv = randomDin();
    if (forceLane0) dinDrv[4][4] = 64'h0011223344556677;
    readyDrv = rdy;
    startDrv = st;
    hs = mValid && rdy;
    lastHs = hs && (mIdx == mL - 1);
    cap = st && (!mValid || lastHs);
    wasStall = mValid && !rdy;
    prevData = obsData;
    prevKeep = obsKeep;
    mDrop = st && mValid && !lastHs;
    if (hs) hsCount++;
    if (lastHs) begin
      checkOutput("hs_count", 64'(hsCount), 64'(mL));
      hsCount = 0;
    end
    if (cap) begin
      mS = specState(dinDrv, curSwap);
      mBits = modeDrv ? 1600 : bitsTable[tidDrv];
      mL = (mBits + curDW - 1) / curDW;
      mIdx = 0;
      mValid = 1'b1;
      mTid = tidDrv;
    end else if (lastHs) begin
      mValid = 1'b0;
    end else if (hs) begin
      mIdx++;
    end
    @(posedge ACLK);
    #1;
    checkOutput("valid", obsValid, mValid);
    checkOutput("busy", obsBusy, mValid);
    checkOutput("start_drop", obsDrop, mDrop);
    if (mValid) begin
      modelWord(mS, mBits, mIdx, curDW, d, k);
      checkOutput("tdata", obsData, d);
      checkOutput("tkeep", obsKeep, k);
      checkOutput("tlast", obsLast, mIdx == mL - 1);
      checkOutput("tid", obsTid, mTid);
    end else begin
      checkOutput("tlast_idle", obsLast, 1'b0);
    end
    if (wasStall) begin
      checkOutput("stall_data", obsData, prevData);
      checkOutput("stall_keep", obsKeep, prevKeep);
    end
    @(negedge ACLK);
  endtask

  // extraStart >= 0 pulses start at that word index; -2 restarts on the last handshake.
  task automatic runDigest(input logic [1:0] tid, input logic mode, input int rdyMode, input int extraStart);
    int guard;
    bit rdy, st, extraDone, toggle;
    guard = 0;
    extraDone = 0;
    toggle = 1'b1;
    tidDrv = tid;
    modeDrv = mode;
    applyStimulus(1'b0, 1'b1);
    while (mValid && guard < 1000) begin
      case (rdyMode)
        0: rdy = 1'b1;
        1: begin rdy = toggle; toggle = ~toggle; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      st = 1'b0;
      if (!extraDone && extraStart >= 0 && mIdx == extraStart) begin
        st = 1'b1;
        extraDone = 1'b1;
      end
      if (!extraDone && extraStart == -2 && rdy && mIdx == mL - 1) begin
        st = 1'b1;
        extraDone = 1'b1;
      end
      applyStimulus(rdy, st);
      guard++;
    end
    checkOutput("digest_done", mValid, 1'b0);
    readyDrv = 1'b0;
    startDrv = 1'b0;
  endtask

  task automatic selectDut(input int s, input int dw, input bit swap);
    sel = s;
    curDW = dw;
    curSwap = swap;
    mValid = 1'b0;
    mDrop = 1'b0;
    hsCount = 0;
    @(negedge ACLK);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int g;
    ARESETn = 1'b0;
    dinDrv = '0; tidDrv = '0; modeDrv = 1'b0; startDrv = 1'b0; readyDrv = 1'b0;
    forceLane0 = 1'b0;
    sel = 0;
    mValid = 1'b0; mDrop = 1'b0; hsCount = 0; mIdx = 0; mL = 1; mBits = 0; mTid = '0; mS = '0;
    curDW = 64; curSwap = 1'b0;
    repeat (2) @(negedge ACLK);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkOutput("rst_valid", obsValid, 1'b0);
      checkOutput("rst_last", obsLast, 1'b0);
      checkOutput("rst_busy", obsBusy, 1'b0);
      checkOutput("rst_drop", obsDrop, 1'b0);
      checkOutput("rst_data", obsData, 64'h0);
      checkOutput("rst_keep", obsKeep, 8'h0);
      checkOutput("rst_tid", obsTid, 2'h0);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;

    selectDut(0, 64, 1'b0);
    runDigest(2'd1, 1'b0, 0, -1);
    runDigest(2'd0, 1'b0, 0, -1);
    runDigest(2'd3, 1'b0, 0, -2);
    runDigest(2'd2, 1'b0, 0, 2);
    runDigest(2'd3, 1'b1, 2, 5);
    for (int i = 0; i < 6; i++)
      runDigest(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2, -1);

    selectDut(1, 16, 1'b0);
    runDigest(2'd2, 1'b1, 1, -1);
    for (int i = 0; i < 3; i++)
      runDigest(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2, 3);

    selectDut(2, 64, 1'b1);
    forceLane0 = 1'b1;
    tidDrv = 2'd3;
    modeDrv = 1'b0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("swap_word0", obsData, 64'h7766554433221100);
    g = 0;
    while (mIdx < 2 && g < 20) begin
      applyStimulus(1'b1, 1'b0);
      g++;
    end
    checkOutput("pre_reset_valid", obsValid, 1'b1);
    ARESETn = 1'b0;
    #1;
    checkOutput("abort_valid", obsValid, 1'b0);
    checkOutput("abort_last", obsLast, 1'b0);
    checkOutput("abort_busy", obsBusy, 1'b0);
    checkOutput("abort_data", obsData, 64'h0);
    mValid = 1'b0; mDrop = 1'b0; hsCount = 0;
    readyDrv = 1'b0; startDrv = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    runDigest(2'd1, 1'b0, 2, -1);
    forceLane0 = 1'b0;
    runDigest(2'($urandom_range(0, 3)), 1'b1, 2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/sha_stream_out.md
SHA_STREAM_OUT -- requirements
Module: sha_stream_out

Interface
REQ-001 Parameter DATA_WIDTH, default 64: output word width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter BYTE_SWAP, default 0: when 1, bytes are reversed within each 64-bit lane before serialization.
REQ-003 ACLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 ARESETn  input  1  asynchronous, active-low reset.
REQ-005 Din  input  [4:0][4:0][63:0]  Keccak state; the flattened vector S places Din[4-k/5][4-k%5] at S[64k+63:64k] for k = 0..24.
REQ-006 TID  input  2  digest select, sampled with start: 0=224, 1=256, 2=384, 3=512 bits.
REQ-007 Mode  input  1  sampled with start: 0 = digest length per TID; 1 = full 1600-bit state.
REQ-008 start  input  1  single-cycle request to capture Din and begin streaming.
REQ-009 m_tdata  output  DATA_WIDTH  output word.
REQ-010 m_tkeep  output  DATA_WIDTH/8  byte-valid mask for m_tdata.
REQ-011 m_tvalid  output  1  AXI-Stream valid.
REQ-012 m_tready  input  1  AXI-Stream ready.
REQ-013 m_tlast  output  1  marks the final word of a digest.
REQ-014 m_tid  output  2  TID captured at start.
REQ-015 busy  output  1  high while in SEND.
REQ-016 start_drop  output  1  single-cycle pulse when start is ignored.

Function
REQ-017 The FSM SHALL have two states, IDLE and SEND.
REQ-018 In IDLE, start=1 SHALL register S (byte-swapped if BYTE_SWAP=1), TID and Mode, clear word counter cnt to 0, and enter SEND; m_tvalid SHALL rise on the following cycle.
REQ-019 The word limit L SHALL be ceil(bits/DATA_WIDTH), where bits = 224/256/384/512 per TID when Mode=0 and 1600 when Mode=1.
REQ-020 In SEND, m_tdata SHALL equal captured S[DATA_WIDTH*(cnt+1)-1 : DATA_WIDTH*cnt], with bits at positions >= bits forced to 0.
REQ-021 m_tkeep SHALL be all ones except on the final word, where only bytes lying below bit position `bits` are set (224/64 -> 8'h0F).
REQ-022 A handshake SHALL be m_tvalid & m_tready; cnt SHALL increment by 1 only on a handshake.
REQ-023 m_tdata, m_tkeep, m_tlast and m_tid SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-024 m_tlast SHALL be high exactly when m_tvalid=1 and cnt = L-1.
REQ-025 A handshake at cnt = L-1 SHALL return the FSM to IDLE with m_tvalid=0 next cycle, unless start=1 in that same cycle, in which case a new capture SHALL occur and SEND continues with cnt=0 (no bubble).
REQ-026 start=1 in SEND, other than in the case of REQ-025, SHALL be ignored and SHALL pulse start_drop for one cycle; the stream in progress SHALL be unaffected.
REQ-027 Din changes after capture SHALL NOT affect the stream in progress.
REQ-028 cnt SHALL be sized to hold 1600/8 = 200 and SHALL never wrap within a digest.
REQ-029 m_tvalid SHALL NOT depend combinationally on m_tready.

Reset
REQ-030 With ARESETn=0, the block SHALL immediately enter IDLE with cnt=0, m_tvalid=0, m_tlast=0, busy=0, start_drop=0, m_tdata=0, m_tkeep=0 and m_tid=0.
REQ-031 Reset asserted mid-stream SHALL abort the digest without emitting m_tlast, and the first start after release SHALL begin a fresh digest at word 0.

Verification
REQ-032 DATA_WIDTH=64, TID=1, Mode=0, m_tready=1 -> 4 words S[63:0]..S[255:192] on consecutive cycles; m_tlast on word 4; m_tkeep=8'hFF throughout.
REQ-033 DATA_WIDTH=64, TID=0 -> 4 words; word 4 has m_tdata[63:32]=0 and m_tkeep=8'h0F with m_tlast=1.
REQ-034 DATA_WIDTH=16, Mode=1, m_tready toggling 1/0 each cycle -> exactly 100 handshakes, data stable during stalls, m_tlast only on handshake 100.
REQ-035 Start asserted in the same cycle as the last handshake of a TID=3 digest -> next digest's word 0 is presented the following cycle; no idle cycle; start_drop=0.
REQ-036 Start pulsed at word 2 of a stream -> start_drop pulses once; the stream completes unchanged.
REQ-037 BYTE_SWAP=1, lane 0 = 64'h0011223344556677 -> first 64-bit word = 64'h7766554433221100; ARESETn pulsed at word 3 -> m_tvalid=0 immediately, no m_tlast.
